// File: rtl/sys_uart_slv_pkg.sv
// Shared constants and types for the sys_uart_slv console UART.
// Register offsets, AXI response codes, serializer states.
package sys_uart_slv_pkg;

  localparam logic [8:0] OFF_TXDATA = 9'd0;
  localparam logic [8:0] OFF_STATUS = 9'd1;
  localparam logic [8:0] OFF_CTRL   = 9'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

  // Only the low two byte lanes of a write matter.
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  strb;
  } w_slot_t;

  function automatic logic [63:0] status_word(
    input logic       full,
    input logic       empty,
    input logic       busy,
    input logic [7:0] cnt
  );
    return {48'd0, cnt, 5'd0, busy, empty, full};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer.
// Ports: clk, rst_n, push/din, pop/dout, full, empty, count.
module uart_tx_fifo #(
  parameter int unsigned DP = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  output logic [7:0]         dout,
  output logic               full,
  output logic               empty,
  output logic [$clog2(DP):0] count
);

  localparam int unsigned AW = $clog2(DP);

  logic [7:0]  mem_q [DP];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;

  // Extra pointer MSB separates full from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign dout  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sys_uart_slv.sv
// AXI4-lite console UART: TXDATA/STATUS/CTRL regs, FIFO, 8N1 TX.
// Ports: CLK, RSTn, AXI-lite AW/W/B/AR/R, UART_TX. Macro: UART_SIM_PRINT_EN.
module sys_uart_slv #(
  parameter int unsigned FIFO_DP = 16,
  parameter logic [15:0] DIV_RST = 16'd868
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] UART_AWADDR,
  input  logic        UART_AWVALID,
  output logic        UART_AWREADY,
  input  logic [63:0] UART_WDATA,
  input  logic [7:0]  UART_WSTRB,
  input  logic        UART_WVALID,
  output logic        UART_WREADY,
  output logic [1:0]  UART_BRESP,
  output logic        UART_BVALID,
  input  logic        UART_BREADY,
  input  logic [31:0] UART_ARADDR,
  input  logic        UART_ARVALID,
  output logic        UART_ARREADY,
  output logic [63:0] UART_RDATA,
  output logic [1:0]  UART_RRESP,
  output logic        UART_RVALID,
  input  logic        UART_RREADY,
  output logic        UART_TX
);

  import sys_uart_slv_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DP) + 1;

  logic          alive_q, alive_d;
  logic          aw_full_q, aw_full_d;
  logic [8:0]    aw_off_q, aw_off_d;
  logic          w_full_q, w_full_d;
  w_slot_t       w_slot_q, w_slot_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [15:0]   div_q, div_d;

  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          exec;
  logic          wr_tx, wr_st, wr_ctl;
  logic          rd_tx, rd_st, rd_ctl;
  logic [8:0]    rd_off;

  logic          fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_cnt;
  logic [8:0]    cnt9;
  logic [7:0]    cnt8;

  ser_state_e    state_q;
  logic [15:0]   bit_cnt_q;
  logic [15:0]   div_lat_q;
  logic [2:0]    idx_q;
  logic [2:0]    idx_nxt;
  logic [7:0]    byte_q;
  logic          tx_q;
  logic          bit_end;
  logic          tx_busy;
  logic [15:0]   div_eff;

  logic          unused_bits;

  assign unused_bits = ^{UART_AWADDR[31:12], UART_AWADDR[2:0],
                         UART_ARADDR[31:12], UART_ARADDR[2:0],
                         UART_WDATA[63:16], UART_WSTRB[7:2]};

  assign UART_AWREADY = alive_q & ~aw_full_q;
  assign UART_WREADY  = alive_q & ~w_full_q;
  assign UART_ARREADY = alive_q & ~rvalid_q;
  assign UART_BVALID  = bvalid_q;
  assign UART_BRESP   = bresp_q;
  assign UART_RVALID  = rvalid_q;
  assign UART_RRESP   = rresp_q;
  assign UART_RDATA   = rdata_q;
  assign UART_TX      = tx_q;

  assign aw_hs = UART_AWVALID & UART_AWREADY;
  assign w_hs  = UART_WVALID & UART_WREADY;
  assign b_hs  = bvalid_q & UART_BREADY;
  assign ar_hs = UART_ARVALID & UART_ARREADY;
  assign r_hs  = rvalid_q & UART_RREADY;
  assign exec  = aw_full_q & w_full_q & ~bvalid_q;

  assign wr_tx  = (aw_off_q == OFF_TXDATA);
  assign wr_st  = (aw_off_q == OFF_STATUS);
  assign wr_ctl = (aw_off_q == OFF_CTRL);

  assign rd_off = UART_ARADDR[11:3];
  assign rd_tx  = (rd_off == OFF_TXDATA);
  assign rd_st  = (rd_off == OFF_STATUS);
  assign rd_ctl = (rd_off == OFF_CTRL);

  assign cnt9    = 9'(fifo_cnt);
  assign cnt8    = cnt9[8] ? 8'hFF : cnt9[7:0];
  assign tx_busy = (state_q != S_IDLE);
  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;

  always_comb begin
    alive_d   = 1'b1;
    aw_full_d = aw_full_q;
    aw_off_d  = aw_off_q;
    w_full_d  = w_full_q;
    w_slot_d  = w_slot_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    div_d     = div_q;
    fifo_push = 1'b0;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_off_d  = UART_AWADDR[11:3];
    end
    if (w_hs) begin
      w_full_d      = 1'b1;
      w_slot_d.data = UART_WDATA[15:0];
      w_slot_d.strb = UART_WSTRB[1:0];
    end
    if (exec) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      unique case (1'b1)
        wr_tx: begin
          if (w_slot_q.strb[0]) begin
            if (fifo_full) bresp_d = RESP_SLVERR;
            else           fifo_push = 1'b1;
          end
        end
        wr_st: bresp_d = RESP_OKAY;
        wr_ctl: begin
          if (w_slot_q.strb[0]) div_d[7:0]  = w_slot_q.data[7:0];
          if (w_slot_q.strb[1]) div_d[15:8] = w_slot_q.data[15:8];
        end
        default: bresp_d = RESP_DECERR;
      endcase
    end
    if (b_hs) begin
      bvalid_d  = 1'b0;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      unique case (1'b1)
        rd_tx:  rdata_d = '0;
        rd_st:  rdata_d = status_word(fifo_full, fifo_empty,
                                      tx_busy, cnt8);
        rd_ctl: rdata_d = {48'd0, div_q};
        default: rresp_d = RESP_DECERR;
      endcase
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      alive_q   <= 1'b0;
      aw_full_q <= 1'b0;
      aw_off_q  <= '0;
      w_full_q  <= 1'b0;
      w_slot_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      div_q     <= DIV_RST;
    end else begin
      alive_q   <= alive_d;
      aw_full_q <= aw_full_d;
      aw_off_q  <= aw_off_d;
      w_full_q  <= w_full_d;
      w_slot_q  <= w_slot_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      div_q     <= div_d;
    end
  end

  uart_tx_fifo #(
    .DP(FIFO_DP)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTn),
    .push  (fifo_push),
    .din   (w_slot_q.data[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Divisor is latched per frame so CTRL writes take
  // effect on the next byte only.
  assign bit_end  = (bit_cnt_q == div_lat_q - 16'd1);
  assign idx_nxt  = idx_q + 3'd1;
  assign fifo_pop = ~fifo_empty &
                    ((state_q == S_IDLE) |
                     ((state_q == S_STOP) & bit_end));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      bit_cnt_q <= '0;
      div_lat_q <= 16'd1;
      idx_q     <= '0;
      byte_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_q   <= S_START;
            tx_q      <= 1'b0;
            bit_cnt_q <= '0;
            byte_q    <= fifo_dout;
            div_lat_q <= div_eff;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q   <= S_DATA;
            tx_q      <= byte_q[0];
            idx_q     <= '0;
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_nxt;
              tx_q  <= byte_q[idx_nxt];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            if (!fifo_empty) begin
              state_q   <= S_START;
              tx_q      <= 1'b0;
              byte_q    <= fifo_dout;
              div_lat_q <= div_eff;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

`ifdef UART_SIM_PRINT_EN
  always_ff @(posedge CLK) begin
    if (fifo_push) $write("%c", w_slot_q.data[7:0]);
  end
`else
`endif

endmodule

// File: tb/tb_sys_uart_slv.sv
// Self-checking bench for sys_uart_slv.
// Scoreboard queues hold expected B/R responses per scenario.
module tb_sys_uart_slv;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] UART_AWADDR;
  logic        UART_AWVALID;
  logic        UART_AWREADY;
  logic [63:0] UART_WDATA;
  logic [7:0]  UART_WSTRB;
  logic        UART_WVALID;
  logic        UART_WREADY;
  logic [1:0]  UART_BRESP;
  logic        UART_BVALID;
  logic        UART_BREADY;
  logic [31:0] UART_ARADDR;
  logic        UART_ARVALID;
  logic        UART_ARREADY;
  logic [63:0] UART_RDATA;
  logic [1:0]  UART_RRESP;
  logic        UART_RVALID;
  logic        UART_RREADY;
  logic        UART_TX;

  int errors = 0;
  int checks = 0;

  logic [1:0]  bq[$];
  logic [65:0] rq[$];

  always #5 CLK = ~CLK;

  sys_uart_slv #(
    .FIFO_DP(16),
    .DIV_RST(16'd868)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .UART_AWADDR  (UART_AWADDR),
    .UART_AWVALID (UART_AWVALID),
    .UART_AWREADY (UART_AWREADY),
    .UART_WDATA   (UART_WDATA),
    .UART_WSTRB   (UART_WSTRB),
    .UART_WVALID  (UART_WVALID),
    .UART_WREADY  (UART_WREADY),
    .UART_BRESP   (UART_BRESP),
    .UART_BVALID  (UART_BVALID),
    .UART_BREADY  (UART_BREADY),
    .UART_ARADDR  (UART_ARADDR),
    .UART_ARVALID (UART_ARVALID),
    .UART_ARREADY (UART_ARREADY),
    .UART_RDATA   (UART_RDATA),
    .UART_RRESP   (UART_RRESP),
    .UART_RVALID  (UART_RVALID),
    .UART_RREADY  (UART_RREADY),
    .UART_TX      (UART_TX)
  );

  task automatic axi_wr(input logic [31:0] a,
                        input logic [63:0] d,
                        input logic [7:0] s,
                        output logic [1:0] resp,
                        output bit ok);
    bit aw_hs, w_hs;
    ok   = 1'b0;
    resp = 2'bxx;
    @(negedge CLK);
    UART_AWADDR  = a;
    UART_AWVALID = 1'b1;
    UART_WDATA   = d;
    UART_WSTRB   = s;
    UART_WVALID  = 1'b1;
    UART_BREADY  = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (UART_BVALID) begin
        resp = UART_BRESP;
        ok   = 1'b1;
      end
      aw_hs = UART_AWVALID & UART_AWREADY;
      w_hs  = UART_WVALID & UART_WREADY;
      @(negedge CLK);
      if (aw_hs) UART_AWVALID = 1'b0;
      if (w_hs)  UART_WVALID  = 1'b0;
    end
    UART_AWVALID = 1'b0;
    UART_WVALID  = 1'b0;
    UART_BREADY  = 1'b0;
  endtask

  task automatic axi_rd(input logic [31:0] a,
                        output logic [63:0] d,
                        output logic [1:0] resp,
                        output int lat,
                        output bit ok);
    bit ar_hs;
    int hs_at;
    hs_at = -1;
    ok    = 1'b0;
    d     = 'x;
    resp  = 2'bxx;
    lat   = -1;
    @(negedge CLK);
    UART_ARADDR  = a;
    UART_ARVALID = 1'b1;
    UART_RREADY  = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      ar_hs = 1'b0;
      if (UART_RVALID) begin
        d    = UART_RDATA;
        resp = UART_RRESP;
        lat  = n - hs_at;
        ok   = 1'b1;
      end else begin
        ar_hs = UART_ARVALID & UART_ARREADY;
        if (ar_hs) hs_at = n;
      end
      @(negedge CLK);
      if (ar_hs) UART_ARVALID = 1'b0;
    end
    UART_ARVALID = 1'b0;
    UART_RREADY  = 1'b0;
  endtask

  task automatic test_reset;
    RSTn = 1'b0;
    UART_AWADDR = '0; UART_AWVALID = 1'b0;
    UART_WDATA = '0; UART_WSTRB = '0; UART_WVALID = 1'b0;
    UART_BREADY = 1'b0;
    UART_ARADDR = '0; UART_ARVALID = 1'b0;
    UART_RREADY = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({UART_AWREADY, UART_WREADY, UART_ARREADY,
         UART_BVALID, UART_RVALID} !== 5'b0)
      begin
        errors++;
        $display("FAIL reset_hs got=%b%b%b%b%b want=00000",
                 UART_AWREADY, UART_WREADY, UART_ARREADY,
                 UART_BVALID, UART_RVALID);
      end
    checks++;
    if ({UART_TX, UART_BRESP, UART_RRESP, UART_RDATA} !==
        {1'b1, 4'b0, 64'd0}) begin
      errors++;
      $display("FAIL reset_out tx=%b bresp=%b rresp=%b rdata=%h",
               UART_TX, UART_BRESP, UART_RRESP, UART_RDATA);
    end
    RSTn = 1'b1;
    @(negedge CLK);
    checks++;
    if ({UART_AWREADY, UART_WREADY, UART_ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL ready_rise got=%b%b%b want=111",
               UART_AWREADY, UART_WREADY, UART_ARREADY);
    end
  endtask

  task automatic test_status_read;
    logic [63:0] d;
    logic [1:0]  r;
    logic [65:0] e;
    int          lat;
    bit          ok;
    rq.push_back({2'b00, 64'h2});
    axi_rd(32'h8, d, r, lat, ok);
    e = rq.pop_front();
    checks++;
    if (!ok || {r, d} !== e) begin
      errors++;
      $display("FAIL status_rst got=%b/%h want=%b/%h ok=%0d",
               r, d, e[65:64], e[63:0], ok);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL r_latency got=%0d want=1", lat);
    end
    rq.push_back({2'b00, 64'h364});
    axi_rd(32'h10, d, r, lat, ok);
    e = rq.pop_front();
    checks++;
    if (!ok || {r, d} !== e) begin
      errors++;
      $display("FAIL ctrl_rst got=%b/%h want=%b/%h",
               r, d, e[65:64], e[63:0]);
    end
  endtask

  task automatic test_frame;
    logic [1:0]  r, eb;
    logic [63:0] d;
    logic [65:0] e;
    logic [7:0]  b;
    logic [43:0] got_w, exp_w;
    int          lat;
    bit          ok, found;
    b = 8'h55;
    bq.push_back(2'b00);
    axi_wr(32'h10, 64'd4, 8'hFF, r, ok);
    eb = bq.pop_front();
    checks++;
    if (!ok || r !== eb) begin
      errors++;
      $display("FAIL ctrl4_wr got=%b want=%b", r, eb);
    end
    bq.push_back(2'b00);
    axi_wr(32'h0, 64'hAA, 8'h00, r, ok);
    eb = bq.pop_front();
    checks++;
    if (!ok || r !== eb) begin
      errors++;
      $display("FAIL nostrb_wr got=%b want=%b", r, eb);
    end
    bq.push_back(2'b00);
    axi_wr(32'h0, {56'd0, b}, 8'h01, r, ok);
    eb = bq.pop_front();
    checks++;
    if (!ok || r !== eb) begin
      errors++;
      $display("FAIL tx55_wr got=%b want=%b", r, eb);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (UART_TX === 1'b0) found = 1'b1;
      else @(negedge CLK);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL start_bit got=none want=low within 20");
    end
    for (int i = 0; i < 44; i++) begin
      if (i < 4)       exp_w[i] = 1'b0;
      else if (i < 36) exp_w[i] = b[(i-4)/4];
      else             exp_w[i] = 1'b1;
    end
    rq.push_back({2'b00, 64'h6});
    fork
      begin
        got_w[0] = UART_TX;
        for (int i = 1; i < 44; i++) begin
          @(negedge CLK);
          got_w[i] = UART_TX;
        end
      end
      begin
        repeat (8) @(negedge CLK);
        axi_rd(32'h8, d, r, lat, ok);
      end
    join
    e = rq.pop_front();
    checks++;
    if (!ok || {r, d} !== e) begin
      errors++;
      $display("FAIL busy_status got=%b/%h want=%b/%h",
               r, d, e[65:64], e[63:0]);
    end
    checks++;
    if (got_w !== exp_w) begin
      errors++;
      $display("FAIL frame55 got=%b want=%b", got_w, exp_w);
    end
    rq.push_back({2'b00, 64'h2});
    axi_rd(32'h8, d, r, lat, ok);
    e = rq.pop_front();
    checks++;
    if (!ok || {r, d} !== e) begin
      errors++;
      $display("FAIL idle_status got=%b/%h want=%b/%h",
               r, d, e[65:64], e[63:0]);
    end
  endtask

  task automatic test_w_before_aw;
    logic [1:0] eb;
    bit         stuck;
    bq.push_back(2'b00);
    @(negedge CLK);
    UART_WDATA  = 64'd8;
    UART_WSTRB  = 8'hFF;
    UART_WVALID = 1'b1;
    UART_BREADY = 1'b0;
    checks++;
    if (UART_WREADY !== 1'b1) begin
      errors++;
      $display("FAIL wready_free got=%b want=1", UART_WREADY);
    end
    @(negedge CLK);
    UART_WVALID = 1'b0;
    checks++;
    if (UART_WREADY !== 1'b0 || UART_BVALID !== 1'b0) begin
      errors++;
      $display("FAIL w_slot_full wready=%b bvalid=%b want=0,0",
               UART_WREADY, UART_BVALID);
    end
    repeat (2) @(negedge CLK);
    UART_AWADDR  = 32'h10;
    UART_AWVALID = 1'b1;
    @(negedge CLK);
    UART_AWVALID = 1'b0;
    checks++;
    if (UART_BVALID !== 1'b0) begin
      errors++;
      $display("FAIL b_early got=%b want=0", UART_BVALID);
    end
    @(negedge CLK);
    eb = bq.pop_front();
    checks++;
    if (UART_BVALID !== 1'b1 || UART_BRESP !== eb) begin
      errors++;
      $display("FAIL b_after_aw bvalid=%b bresp=%b want=1,%b",
               UART_BVALID, UART_BRESP, eb);
    end
    stuck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (UART_BVALID !== 1'b1 || UART_AWREADY !== 1'b0 ||
          UART_WREADY !== 1'b0) stuck = 1'b1;
    end
    checks++;
    if (stuck) begin
      errors++;
      $display("FAIL b_hold got=changed want=held");
    end
    UART_BREADY = 1'b1;
    @(negedge CLK);
    UART_BREADY = 1'b0;
    checks++;
    if ({UART_BVALID, UART_AWREADY, UART_WREADY} !== 3'b011) begin
      errors++;
      $display("FAIL b_release got=%b%b%b want=011",
               UART_BVALID, UART_AWREADY, UART_WREADY);
    end
  endtask

  task automatic test_decode;
    logic [31:0] ra [5];
    logic [65:0] re [5];
    logic [63:0] d;
    logic [1:0]  r, eb;
    logic [65:0] e;
    int          lat;
    bit          ok;
    bq.push_back(2'b11);
    axi_wr(32'h18, 64'hFFFF, 8'hFF, r, ok);
    eb = bq.pop_front();
    checks++;
    if (!ok || r !== eb) begin
      errors++;
      $display("FAIL decerr_wr got=%b want=%b", r, eb);
    end
    bq.push_back(2'b00);
    axi_wr(32'hFFFF_F014, 64'h12CD, 8'h01, r, ok);
    eb = bq.pop_front();
    checks++;
    if (!ok || r !== eb) begin
      errors++;
      $display("FAIL ctrl_lane0 got=%b want=%b", r, eb);
    end
    ra[0] = 32'h40;        re[0] = {2'b11, 64'd0};
    ra[1] = 32'h10;        re[1] = {2'b00, 64'hCD};
    ra[2] = 32'h0;         re[2] = {2'b00, 64'd0};
    ra[3] = 32'h0000_0017; re[3] = {2'b00, 64'hCD};
    ra[4] = 32'hABCD_E00C; re[4] = {2'b00, 64'h2};
    for (int i = 0; i < 5; i++) begin
      rq.push_back(re[i]);
      axi_rd(ra[i], d, r, lat, ok);
      e = rq.pop_front();
      checks++;
      if (!ok || {r, d} !== e) begin
        errors++;
        $display("FAIL decode_rd%0d got=%b/%h want=%b/%h",
                 i, r, d, e[65:64], e[63:0]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [1:0]  r, eb;
    logic [7:0]  b;
    logic [11:0] got_w, exp_w;
    bit          ok, found;
    b = 8'h0F;
    bq.push_back(2'b00);
    axi_wr(32'h10, 64'd0, 8'h03, r, ok);
    bq.push_back(2'b00);
    axi_wr(32'h0, {56'd0, b}, 8'h01, r, ok);
    eb = bq.pop_front();
    eb = bq.pop_front();
    checks++;
    if (!ok || r !== eb) begin
      errors++;
      $display("FAIL div0_push got=%b want=%b", r, eb);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (UART_TX === 1'b0) found = 1'b1;
      else @(negedge CLK);
    end
    got_w[0] = UART_TX;
    for (int i = 1; i < 12; i++) begin
      @(negedge CLK);
      got_w[i] = UART_TX;
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 0)      exp_w[i] = 1'b0;
      else if (i < 9)  exp_w[i] = b[i-1];
      else             exp_w[i] = 1'b1;
    end
    checks++;
    if (!found || got_w !== exp_w) begin
      errors++;
      $display("FAIL frame_div0 got=%b want=%b", got_w, exp_w);
    end
  endtask

  task automatic test_overflow;
    logic [1:0]  got_r [18];
    bit          got_ok [18];
    logic [1:0]  r, eb;
    logic [63:0] d;
    logic [65:0] e;
    int          lat;
    bit          ok;
    bq.push_back(2'b00);
    axi_wr(32'h10, 64'd1000, 8'hFF, r, ok);
    eb = bq.pop_front();
    checks++;
    if (!ok || r !== eb) begin
      errors++;
      $display("FAIL ctrl1000 got=%b want=%b", r, eb);
    end
    // First byte leaves for the serializer at once, so 17 fit.
    for (int i = 0; i < 18; i++)
      bq.push_back(i < 17 ? 2'b00 : 2'b10);
    for (int i = 0; i < 18; i++)
      axi_wr(32'h0, 64'(i), 8'h01, got_r[i], got_ok[i]);
    for (int i = 0; i < 18; i++) begin
      eb = bq.pop_front();
      checks++;
      if (!got_ok[i] || got_r[i] !== eb) begin
        errors++;
        $display("FAIL push%0d got=%b want=%b", i, got_r[i], eb);
      end
    end
    rq.push_back({2'b00, 64'h1005});
    axi_rd(32'h8, d, r, lat, ok);
    e = rq.pop_front();
    checks++;
    if (!ok || {r, d} !== e) begin
      errors++;
      $display("FAIL full_status got=%b/%h want=%b/%h",
               r, d, e[65:64], e[63:0]);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] d;
    logic [1:0]  r;
    logic [65:0] e;
    int          lat;
    bit          ok, found;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      if (UART_TX === 1'b0) found = 1'b1;
      else @(negedge CLK);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midframe_low got=none want=low");
    end
    RSTn = 1'b0;
    #1;
    checks++;
    if (UART_TX !== 1'b1) begin
      errors++;
      $display("FAIL rst_tx got=%b want=1", UART_TX);
    end
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    rq.push_back({2'b00, 64'h2});
    axi_rd(32'h8, d, r, lat, ok);
    e = rq.pop_front();
    checks++;
    if (!ok || {r, d} !== e) begin
      errors++;
      $display("FAIL rst_status got=%b/%h want=%b/%h",
               r, d, e[65:64], e[63:0]);
    end
    rq.push_back({2'b00, 64'h364});
    axi_rd(32'h10, d, r, lat, ok);
    e = rq.pop_front();
    checks++;
    if (!ok || {r, d} !== e) begin
      errors++;
      $display("FAIL rst_ctrl got=%b/%h want=%b/%h",
               r, d, e[65:64], e[63:0]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_status_read();
    test_frame();
    test_w_before_aw();
    test_decode();
    test_div_zero();
    test_overflow();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
